regalu_sequencer: RTL and testbench
===================================

// Module: regalu_sequencer
// PURPOSE
//  Instruction sequencer for the RegFile_Alu datapath. Buffers instruction words from a
//  requester in a small FIFO and issues each one as a single-cycle write (En pulse) with
//  stable RdestRegLoc/RsrcRegLoc/Imm/Imm_s/OpCode. Captures ALU Flags after every write.
//  Supports halt/resume and flush. Sits between a program source (ROM/host) and RegFile_Alu.
// PARAMETERS
//  DEPTH   4   instruction FIFO entries; power of 2, >= 2
//  CNT_W   8   width of IssueCount
// PORTS
//  Clk          in   1      system clock; all state updates on rising edge
//  Rst          in   1      asynchronous, active-low reset
//  InstrIn      in   32     [31:28] OpCode, [27:24] Rdest, [23:20] Rsrc, [19] Imm_s,
//                           [18] Halt, [17:16] reserved (ignored), [15:0] Imm
//  InstrValid   in   1      InstrIn valid this cycle
//  InstrReady   out  1      FIFO can accept InstrIn this cycle
//  Resume       in   1      leave HALT (single-cycle pulse)
//  Flush        in   1      discard FIFO contents and return to IDLE
//  Flags        in   5      flag output from RegFile_Alu
//  RdestRegLoc  out  4      to RegFile_Alu
//  RsrcRegLoc   out  4      to RegFile_Alu
//  Imm          out  16     to RegFile_Alu
//  Imm_s        out  1      to RegFile_Alu; 1 = Imm operand, 0 = Rsrc operand
//  OpCode       out  4      to RegFile_Alu
//  En           out  1      RegFile write enable
//  FlagsOut     out  5      Flags captured after the last completed write
//  Done         out  1      one-cycle pulse when FlagsOut updates
//  Busy         out  1      state != IDLE or FIFO non-empty
//  Halted       out  1      state == HALT
//  IssueCount   out  CNT_W  number of En pulses issued; wraps 2^CNT_W-1 -> 0
// BEHAVIOUR
//  - Reset (Rst=0, async): FIFO empty, state IDLE, every output 0 except InstrReady=1.
//  - All datapath drive outputs (RdestRegLoc..En) are registered; no comb path from inputs.
//  - Push: on rising edge when InstrValid & InstrReady. InstrReady = !full & !Flush.
//    Full judged on registered count: a pop in the same cycle does not admit a push when full.
//  - FSM states: IDLE, ISSUE, WAIT, HALT.
//    IDLE : FIFO non-empty -> pop head; Halt bit=1 -> HALT (no En, fields unchanged);
//           else load fields, En<=1 -> ISSUE.
//    ISSUE: En high exactly this one cycle; RegFile writes at its end; En<=0 -> WAIT.
//           IssueCount increments at the edge leaving ISSUE.
//    WAIT : FlagsOut<=Flags, Done<=1 at edge leaving WAIT; then same decision as IDLE
//           (pop next if available, else IDLE). Fields hold their last values while not issuing.
//    HALT : no pops; pushes still accepted until full. Resume=1 -> IDLE.
//  - Latency: push at edge k into empty FIFO in IDLE -> pop at k+1, En high k+1..k+2,
//    FlagsOut/Done at k+3. Sustained throughput: one instruction per 2 cycles.
//  - Flush (sync, priority over all but reset): FIFO emptied, state IDLE, En<=0 next edge.
//    A write whose En is already high completes; FlagsOut/Done not updated for it.
//    Flush overrides Resume and push in the same cycle. IssueCount and FlagsOut retained.
//  - Resume outside HALT ignored. Halt word consumes a FIFO slot, never raises En or Done.
//  - Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
// TESTING
//  1 Reset mid-ISSUE: drop Rst with En=1 -> En, Done, count, FlagsOut 0 immediately; InstrReady=1.
//  2 Program ADDI r0,#1 (0x0008_0001); ADDI r1,#2 (0x0108_0002); ADD r1,r0 (0x0100_0000)
//    with real RegFile_Alu -> 3 En pulses 2 cycles apart, IssueCount=3, RdestOut=3.
//  3 Halt word first, then push 5 words -> Halted=1, 4 accepted, InstrReady=0 on 5th
//    (DEPTH=4 counts Halt's slot freed), no En until Resume; then 4 writes in order.
//  4 Full FIFO, pop and push same cycle -> push refused, InstrReady rises next cycle.
//  5 Flush during WAIT with 3 queued -> no further En, Busy=0 next cycle, Done not pulsed.
//  6 Issue 257 ADD words with CNT_W=8 -> IssueCount wraps to 1; Done pulses 257 times.

Source files
------------

// File: rtl/regalu_sequencer.sv
// Instruction sequencer for RegFile_Alu: buffers instruction words in a FIFO and issues each
// as a one-cycle register-file write, capturing the ALU flags after every completed write.
module regalu_sequencer #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic [31:0]      InstrIn,
   input  logic             InstrValid,
   output logic             InstrReady,
   input  logic             Resume,
   input  logic             Flush,
   input  logic [4:0]       Flags,
   output logic [3:0]       RdestRegLoc,
   output logic [3:0]       RsrcRegLoc,
   output logic [15:0]      Imm,
   output logic             Imm_s,
   output logic [3:0]       OpCode,
   output logic             En,
   output logic [4:0]       FlagsOut,
   output logic             Done,
   output logic             Busy,
   output logic             Halted,
   output logic [CNT_W-1:0] IssueCount
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef logic [AW-1:0] ptr_t;
   typedef logic [AW:0]   fill_t;
   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_HALT} state_t;

   typedef struct packed {
      logic [3:0]  opcode;
      logic [3:0]  rdest;
      logic [3:0]  rsrc;
      logic        imm_s;
      logic        halt;
      logic [15:0] imm;
   } instr_t;

   typedef struct packed {
      logic [3:0]  opcode;
      logic [3:0]  rdest;
      logic [3:0]  rsrc;
      logic        imm_s;
      logic [15:0] imm;
   } fields_t;

   instr_t           mem [DEPTH];
   instr_t           in_word, head;
   ptr_t             wr_ptr, rd_ptr;
   fill_t            fill;
   state_t           state, state_nxt;
   fields_t          fields, fields_nxt;
   logic             en_nxt, done_nxt, pop, push, full, empty;
   logic [4:0]       flags_nxt;
   logic [CNT_W-1:0] count_nxt;
   logic             reserved_unused;

   // Reserved bits [17:16] are dropped before storage.
   assign in_word         = {InstrIn[31:18], InstrIn[15:0]};
   assign reserved_unused = ^InstrIn[17:16];

   assign full       = (fill == fill_t'(DEPTH));
   assign empty      = (fill == '0);
   assign InstrReady = !full && !Flush;
   assign push       = InstrValid && InstrReady;
   assign head       = mem[rd_ptr];

   // NOTE: the storage array has no reset; the pointers and fill level alone qualify its contents.
   always_ff @(posedge Clk) begin
      if (push) mem[wr_ptr] <= in_word;
   end

   // NOTE: all state uses non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill   <= '0;
      end else if (Flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill   <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + ptr_t'(1);
         if (pop)  rd_ptr <= rd_ptr + ptr_t'(1);
         case ({push, pop})
            2'b10:   fill <= fill + fill_t'(1);
            2'b01:   fill <= fill - fill_t'(1);
            default: fill <= fill;
         endcase
      end
   end

   // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
   always_comb begin
      state_nxt  = state;
      fields_nxt = fields;
      en_nxt     = 1'b0;
      done_nxt   = 1'b0;
      flags_nxt  = FlagsOut;
      count_nxt  = IssueCount;
      pop        = 1'b0;
      if (Flush) begin
         // A write already on the bus still completes, so it is still counted.
         state_nxt = ST_IDLE;
         if (state == ST_ISSUE) count_nxt = IssueCount + CNT_W'(1);
      end else begin
         case (state)
            ST_ISSUE: begin
               count_nxt = IssueCount + CNT_W'(1);
               state_nxt = ST_WAIT;
            end
            ST_HALT: begin
               if (Resume) state_nxt = ST_IDLE;
            end
            default: begin
               if (state == ST_WAIT) begin
                  flags_nxt = Flags;
                  done_nxt  = 1'b1;
                  state_nxt = ST_IDLE;
               end
               if (!empty) begin
                  pop = 1'b1;
                  if (head.halt) begin
                     state_nxt = ST_HALT;
                  end else begin
                     fields_nxt = '{head.opcode, head.rdest, head.rsrc, head.imm_s, head.imm};
                     en_nxt     = 1'b1;
                     state_nxt  = ST_ISSUE;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state      <= ST_IDLE;
         fields     <= '0;
         En         <= 1'b0;
         Done       <= 1'b0;
         FlagsOut   <= '0;
         IssueCount <= '0;
      end else begin
         state      <= state_nxt;
         fields     <= fields_nxt;
         En         <= en_nxt;
         Done       <= done_nxt;
         FlagsOut   <= flags_nxt;
         IssueCount <= count_nxt;
      end
   end

   assign {OpCode, RdestRegLoc, RsrcRegLoc, Imm_s, Imm} = fields;
   assign Busy   = (state != ST_IDLE) || !empty;
   assign Halted = (state == ST_HALT);

endmodule

// File: tb/tb_regalu_sequencer.sv
// Bench for regalu_sequencer: table-driven decode vectors feeding an issue/flags scoreboard,
// plus directed latency, halt, full-FIFO, flush, reset and counter-wrap sequences.
module tb_regalu_sequencer;
   typedef struct packed {
      logic [3:0]  op;
      logic [3:0]  rd;
      logic [3:0]  rs;
      logic        s;
      logic [15:0] imm;
   } fld_t;

   typedef struct {
      logic [31:0] word;
      fld_t        exp;
   } vec_t;

   logic        Clk = 1'b0;
   logic        Rst = 1'b0;
   logic [31:0] InstrIn = '0;
   logic        InstrValid = 1'b0;
   logic        Resume = 1'b0;
   logic        Flush = 1'b0;
   logic [4:0]  Flags = '0;
   logic        InstrReady, En, Imm_s, Done, Busy, Halted;
   logic [3:0]  RdestRegLoc, RsrcRegLoc, OpCode;
   logic [15:0] Imm;
   logic [4:0]  FlagsOut;
   logic [7:0]  IssueCount;

   regalu_sequencer #(.DEPTH(4), .CNT_W(8)) dut (
      .Clk(Clk), .Rst(Rst), .InstrIn(InstrIn), .InstrValid(InstrValid), .InstrReady(InstrReady),
      .Resume(Resume), .Flush(Flush), .Flags(Flags), .RdestRegLoc(RdestRegLoc),
      .RsrcRegLoc(RsrcRegLoc), .Imm(Imm), .Imm_s(Imm_s), .OpCode(OpCode), .En(En),
      .FlagsOut(FlagsOut), .Done(Done), .Busy(Busy), .Halted(Halted), .IssueCount(IssueCount)
   );

   always #5 Clk = ~Clk;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         done_seen = 0;
   int         n_issue = 0;
   int         en_cyc[$];
   fld_t       exp_q[$];
   logic [4:0] done_q[$];
   fld_t       mon_e;
   fld_t       last_fld = '0;
   logic [4:0] last_flags = '0;
   logic       prev_en = 1'b0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   function automatic fld_t dut_fields();
      return {OpCode, RdestRegLoc, RsrcRegLoc, Imm_s, Imm};
   endfunction

   function automatic logic [31:0] word_of(input fld_t f, input logic halt);
      return {f.op, f.rd, f.rs, f.s, halt, 2'b00, f.imm};
   endfunction

   // Stand-in for the ALU: flags for a write are a fixed function of that write's fields.
   function automatic logic [4:0] flag_of(input fld_t f);
      return f.imm[4:0] ^ {1'b0, f.rd} ^ {f.s, f.op};
   endfunction

   initial forever @(posedge Clk) cyc++;

   // Issue/flags monitor: pops the scoreboard on every En and every Done.
   initial forever begin
      @(negedge Clk);
      if (Rst) begin
         if (En) begin
            check("en_single_cycle", prev_en, 0);
            if (exp_q.size() == 0) begin
               check("en_with_empty_scoreboard", En, 0);
            end else begin
               mon_e = exp_q.pop_front();
               check("issue_fields", dut_fields(), mon_e);
               Flags = flag_of(mon_e);
               done_q.push_back(flag_of(mon_e));
               last_fld = mon_e;
               en_cyc.push_back(cyc);
            end
         end
         if (Done) begin
            done_seen++;
            if (done_q.size() == 0) begin
               check("done_with_nothing_pending", Done, 0);
            end else begin
               last_flags = done_q.pop_front();
               check("flags_out", FlagsOut, last_flags);
            end
         end
      end
      prev_en = En;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $fatal(1);
   end

   task automatic push_try(input logic [31:0] w, input fld_t f, input logic halt,
                           input logic exp_acc, input string name);
      @(negedge Clk);
      InstrIn = w;
      InstrValid = 1'b1;
      #1;
      check(name, InstrReady, exp_acc);
      if (exp_acc && !halt) begin
         exp_q.push_back(f);
         n_issue++;
      end
      @(posedge Clk);
      #1 InstrValid = 1'b0;
   endtask

   task automatic push_wait(input logic [31:0] w, input fld_t f);
      int n = 0;
      @(negedge Clk);
      InstrIn = w;
      InstrValid = 1'b1;
      #1;
      while (!InstrReady && n < 50) begin
         @(negedge Clk);
         #1;
         n++;
      end
      check("push_accepted_in_time", InstrReady, 1);
      exp_q.push_back(f);
      n_issue++;
      @(posedge Clk);
      #1 InstrValid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      do begin
         @(negedge Clk);
         #2;
         n++;
      end while ((exp_q.size() != 0 || done_q.size() != 0 || Busy) && n < 2000);
      check({name, "_drained_in_time"}, (n < 2000), 1);
      check({name, "_idle"}, Busy, 0);
   endtask

   task automatic resume_pulse();
      @(negedge Clk);
      Resume = 1'b1;
      @(posedge Clk);
      #1 Resume = 1'b0;
   endtask

   initial begin
      vec_t vt[8];
      fld_t hw[5];
      fld_t f;
      int   d0;
      int   n;

      vt[0] = '{32'h0008_0001, '{4'h0, 4'h0, 4'h0, 1'b1, 16'h0001}};
      vt[1] = '{32'h0108_0002, '{4'h0, 4'h1, 4'h0, 1'b1, 16'h0002}};
      vt[2] = '{32'h0100_0000, '{4'h0, 4'h1, 4'h0, 1'b0, 16'h0000}};
      vt[3] = '{32'h5A3B_FFFF, '{4'h5, 4'hA, 4'h3, 1'b1, 16'hFFFF}};
      vt[4] = '{32'hF0F3_8001, '{4'hF, 4'h0, 4'hF, 1'b0, 16'h8001}};
      vt[5] = '{32'h9C6A_1234, '{4'h9, 4'hC, 4'h6, 1'b1, 16'h1234}};
      vt[6] = '{32'h3E72_0000, '{4'h3, 4'hE, 4'h7, 1'b0, 16'h0000}};
      vt[7] = '{32'hC5D8_ABCD, '{4'hC, 4'h5, 4'hD, 1'b1, 16'hABCD}};
      for (int i = 0; i < 5; i++)
         hw[i] = '{4'(i + 1), 4'(i + 6), 4'(15 - i), i[0], 16'(32'h1000 + i)};

      // Reset state
      repeat (2) @(negedge Clk);
      check("rst_en", En, 0);
      check("rst_ready", InstrReady, 1);
      check("rst_busy", Busy, 0);
      check("rst_halted", Halted, 0);
      check("rst_done", Done, 0);
      check("rst_count", IssueCount, 0);
      check("rst_flags", FlagsOut, 0);
      check("rst_fields", dut_fields(), 0);
      Rst = 1'b1;

      // Latency: push at edge k -> En over k+1..k+2, Done at k+3
      f = '{4'h2, 4'h3, 4'h4, 1'b0, 16'h0042};
      @(negedge Clk);
      InstrIn = word_of(f, 1'b0);
      InstrValid = 1'b1;
      exp_q.push_back(f);
      n_issue++;
      @(posedge Clk);
      #1 InstrValid = 1'b0;
      @(negedge Clk);
      check("lat_k0_en", En, 0);
      check("lat_k0_busy", Busy, 1);
      @(negedge Clk);
      check("lat_k1_en", En, 1);
      check("lat_k1_count", IssueCount, 0);
      @(negedge Clk);
      check("lat_k2_en", En, 0);
      check("lat_k2_count", IssueCount, 1);
      check("lat_k2_done", Done, 0);
      @(negedge Clk);
      check("lat_k3_done", Done, 1);
      check("lat_k3_busy", Busy, 0);
      @(negedge Clk);
      check("lat_k4_done", Done, 0);

      // Decode table, pushed back to back: issues must stream one per two cycles
      en_cyc.delete();
      for (int i = 0; i < 8; i++) push_wait(vt[i].word, vt[i].exp);
      wait_drain("table");
      check("table_issue_total", en_cyc.size(), 8);
      for (int i = 1; i < en_cyc.size(); i++)
         check("issue_spacing", en_cyc[i] - en_cyc[i-1], 2);
      check("table_count", IssueCount, n_issue[7:0]);

      // Halt word first, then five pushes: four fit, fifth refused, nothing issues
      push_try(32'h0004_0000, '0, 1'b1, 1'b1, "halt_word_ready");
      for (int i = 0; i < 5; i++)
         push_try(word_of(hw[i], 1'b0), hw[i], 1'b0, (i < 4), "halt_fill_ready");
      check("halted", Halted, 1);
      check("fields_held_over_halt", dut_fields(), last_fld);
      repeat (5) begin
         @(negedge Clk);
         check("no_en_in_halt", En, 0);
         check("busy_in_halt", Busy, 1);
      end

      // Resume with a full FIFO: the pop edge does not admit a push, the next cycle does
      resume_pulse();
      push_try(word_of(hw[4], 1'b0), hw[4], 1'b0, 1'b0, "full_pop_push_refused");
      check("halt_left", Halted, 0);
      push_try(word_of(hw[4], 1'b0), hw[4], 1'b0, 1'b1, "ready_after_pop");
      wait_drain("halt");
      check("halt_count", IssueCount, n_issue[7:0]);

      // Flush during WAIT with three queued
      push_try(32'h0004_0000, '0, 1'b1, 1'b1, "flush_halt_ready");
      for (int i = 0; i < 4; i++)
         push_try(word_of(vt[i+4].exp, 1'b0), vt[i+4].exp, 1'b0, 1'b1, "flush_fill_ready");
      resume_pulse();
      @(negedge Clk);
      @(negedge Clk);
      check("flush_pre_en", En, 1);
      @(negedge Clk);
      check("flush_wait_en", En, 0);
      Flush = 1'b1;
      InstrIn = 32'h0000_0001;
      InstrValid = 1'b1;
      #1;
      check("flush_blocks_push", InstrReady, 0);
      @(posedge Clk);
      #1;
      Flush = 1'b0;
      InstrValid = 1'b0;
      n_issue = n_issue - exp_q.size();
      exp_q.delete();
      done_q.delete();
      @(negedge Clk);
      check("flush_busy", Busy, 0);
      check("flush_done", Done, 0);
      check("flush_flags_kept", FlagsOut, last_flags);
      check("flush_count_kept", IssueCount, n_issue[7:0]);
      repeat (6) begin
         @(negedge Clk);
         check("no_en_after_flush", En, 0);
         check("no_done_after_flush", Done, 0);
      end

      // Asynchronous reset while En is high
      push_wait(32'h7123_0055, '{4'h7, 4'h1, 4'h2, 1'b0, 16'h0055});
      n = 0;
      do begin
         @(negedge Clk);
         n++;
      end while (!En && n < 10);
      check("reset_test_en_seen", En, 1);
      #1 Rst = 1'b0;
      #1;
      check("midrst_en", En, 0);
      check("midrst_done", Done, 0);
      check("midrst_count", IssueCount, 0);
      check("midrst_flags", FlagsOut, 0);
      check("midrst_ready", InstrReady, 1);
      check("midrst_busy", Busy, 0);
      exp_q.delete();
      done_q.delete();
      n_issue = 0;
      @(negedge Clk);
      Rst = 1'b1;

      // 257 writes from a fresh reset: IssueCount wraps to 1
      d0 = done_seen;
      for (int i = 0; i < 257; i++) begin
         f = '{4'h0, i[3:0], 4'(i + 1), 1'b0, i[15:0]};
         push_wait(word_of(f, 1'b0), f);
      end
      wait_drain("wrap");
      check("wrap_count", IssueCount, 1);
      check("wrap_done_pulses", done_seen - d0, 257);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
